// File: rtl/axis_pfifo_pkg.sv
// Shared types for the AXI-Stream packet FIFO: write-side FSM encoding and
// the FIFO mode selector value.
package axis_pfifo_pkg;

    localparam int MODE_PACKET = 1;

    typedef enum logic [0:0] {
        WR_FILL    = 1'b0,
        WR_DISCARD = 1'b1
    } wr_state_t;

endpackage

// File: rtl/axis_pfifo_ram.sv
// Simple dual-port storage for {tlast, tdata}: one write port, one read port
// whose data register doubles as the FWFT output stage of the FIFO.
module axis_pfifo_ram #(
    parameter int DW = 9,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Output beat must read as zero out of reset, so this register is reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axis_pfifo.sv
// Single-clock AXI-Stream FIFO with optional store-and-forward frame mode,
// frame abort (drop_i) and oversize-frame discard.
module axis_pfifo
    import axis_pfifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ABITS  = 4,
    parameter int PACKET = 1
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             s_tvalid_i,
    output logic             s_tready_o,
    input  logic             s_tlast_i,
    input  logic [WIDTH-1:0] s_tdata_i,
    input  logic             drop_i,
    output logic             m_tvalid_o,
    input  logic             m_tready_i,
    output logic             m_tlast_o,
    output logic [WIDTH-1:0] m_tdata_o,
    output logic [ABITS:0]   level_o,
    output logic             dropped_o
);

    localparam bit             PKT     = (PACKET == MODE_PACKET);
    localparam logic [ABITS:0] PTR_ONE = {{ABITS{1'b0}}, 1'b1};

    logic [ABITS:0] r_wr;
    logic [ABITS:0] r_cm;
    logic [ABITS:0] r_rd;
    logic           r_mvalid;
    logic           r_dropped;
    wr_state_t      r_state;
    wr_state_t      w_state_nxt;

    logic           w_full;
    logic           w_discarding;
    logic           w_accept;
    logic           w_drop;
    logic           w_overflow;
    logic           w_we;
    logic           w_pop;
    logic           w_re;
    logic [ABITS:0] w_cm;
    logic [ABITS:0] w_rd_nxt;
    logic [WIDTH:0] w_rdata;

    assign w_full       = (r_wr[ABITS] != r_rd[ABITS]) &&
                          (r_wr[ABITS-1:0] == r_rd[ABITS-1:0]);
    assign w_discarding = PKT && (r_state == WR_DISCARD);
    assign s_tready_o   = ~w_full | w_discarding;
    assign w_accept     = s_tvalid_i & s_tready_o;

    // A stuck partial frame that fills the whole FIFO can never commit.
    assign w_drop     = PKT && drop_i && (r_state == WR_FILL);
    assign w_overflow = PKT && (r_state == WR_FILL) && w_full && (r_wr != r_cm);
    assign w_we       = w_accept && !w_discarding && !w_drop;

    assign w_cm     = PKT ? r_cm : r_wr;
    assign w_pop    = r_mvalid & m_tready_i;
    assign w_rd_nxt = r_rd + {{ABITS{1'b0}}, w_pop};
    // Re-reading the head while stalled keeps the beat stable: its slot
    // cannot be overwritten until it is popped.
    assign w_re     = (w_rd_nxt != w_cm);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WR_FILL: begin
                if (w_overflow) begin
                    w_state_nxt = WR_DISCARD;
                end
            end
            WR_DISCARD: begin
                if (s_tvalid_i && s_tlast_i) begin
                    w_state_nxt = WR_FILL;
                end
            end
            default: w_state_nxt = WR_FILL;
        endcase
        if (!PKT) begin
            w_state_nxt = WR_FILL;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= WR_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr      <= '0;
            r_cm      <= '0;
            r_rd      <= '0;
            r_mvalid  <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_rd      <= w_rd_nxt;
            r_mvalid  <= w_re;
            r_dropped <= w_drop | w_overflow;
            if (w_drop || w_overflow) begin
                r_wr <= r_cm;
            end else if (w_we) begin
                r_wr <= r_wr + PTR_ONE;
            end
            if (PKT && w_we && s_tlast_i) begin
                r_cm <= r_wr + PTR_ONE;
            end
        end
    end

    axis_pfifo_ram #(
        .DW (WIDTH + 1),
        .AW (ABITS)
    ) u_ram (
        .i_clk   (aclk),
        .i_rst   (areset),
        .i_we    (w_we),
        .i_waddr (r_wr[ABITS-1:0]),
        .i_wdata ({s_tlast_i, s_tdata_i}),
        .i_re    (w_re),
        .i_raddr (w_rd_nxt[ABITS-1:0]),
        .o_rdata (w_rdata)
    );

    assign m_tvalid_o = r_mvalid;
    assign m_tlast_o  = w_rdata[WIDTH];
    assign m_tdata_o  = w_rdata[WIDTH-1:0];
    assign level_o    = r_wr - r_rd;
    assign dropped_o  = r_dropped;

endmodule

// File: tb/tb_axis_pfifo.sv
// Directed bench for axis_pfifo: stream mode, frame commit, drop, oversize
// discard, full-FIFO concurrent traffic and mid-frame reset.
module tb_axis_pfifo;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    logic       s0_tvalid, s0_tready, s0_tlast, d0_drop, m0_tvalid, m0_tready, m0_tlast, dr0;
    logic [7:0] s0_tdata, m0_tdata;
    logic [4:0] l0;
    logic       s1_tvalid, s1_tready, s1_tlast, d1_drop, m1_tvalid, m1_tready, m1_tlast, dr1;
    logic [7:0] s1_tdata, m1_tdata;
    logic [4:0] l1;
    logic       s2_tvalid, s2_tready, s2_tlast, d2_drop, m2_tvalid, m2_tready, m2_tlast, dr2;
    logic [7:0] s2_tdata, m2_tdata;
    logic [2:0] l2;

    axis_pfifo #(.WIDTH(8), .ABITS(4), .PACKET(0)) u0 (
        .aclk(aclk), .areset(areset), .s_tvalid_i(s0_tvalid), .s_tready_o(s0_tready),
        .s_tlast_i(s0_tlast), .s_tdata_i(s0_tdata), .drop_i(d0_drop), .m_tvalid_o(m0_tvalid),
        .m_tready_i(m0_tready), .m_tlast_o(m0_tlast), .m_tdata_o(m0_tdata), .level_o(l0),
        .dropped_o(dr0));

    axis_pfifo #(.WIDTH(8), .ABITS(4), .PACKET(1)) u1 (
        .aclk(aclk), .areset(areset), .s_tvalid_i(s1_tvalid), .s_tready_o(s1_tready),
        .s_tlast_i(s1_tlast), .s_tdata_i(s1_tdata), .drop_i(d1_drop), .m_tvalid_o(m1_tvalid),
        .m_tready_i(m1_tready), .m_tlast_o(m1_tlast), .m_tdata_o(m1_tdata), .level_o(l1),
        .dropped_o(dr1));

    axis_pfifo #(.WIDTH(8), .ABITS(2), .PACKET(1)) u2 (
        .aclk(aclk), .areset(areset), .s_tvalid_i(s2_tvalid), .s_tready_o(s2_tready),
        .s_tlast_i(s2_tlast), .s_tdata_i(s2_tdata), .drop_i(d2_drop), .m_tvalid_o(m2_tvalid),
        .m_tready_i(m2_tready), .m_tlast_o(m2_tlast), .m_tdata_o(m2_tdata), .level_o(l2),
        .dropped_o(dr2));

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        s0_tvalid = 0; s0_tlast = 0; s0_tdata = 0; d0_drop = 0; m0_tready = 0;
        s1_tvalid = 0; s1_tlast = 0; s1_tdata = 0; d1_drop = 0; m1_tready = 0;
        s2_tvalid = 0; s2_tlast = 0; s2_tdata = 0; d2_drop = 0; m2_tready = 0;
        tick(); tick();
        checks++; if (m0_tvalid !== 1'b0) begin errors++; $display("FAIL reset_mvalid got %0b want 0", m0_tvalid); end
        checks++; if (l0 !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", l0); end
        checks++; if (s0_tready !== 1'b1) begin errors++; $display("FAIL reset_sready got %0b want 1", s0_tready); end
        checks++; if ({m0_tlast, m0_tdata} !== 9'h000) begin errors++; $display("FAIL reset_mdata got %h want 000", {m0_tlast, m0_tdata}); end
        checks++; if (dr1 !== 1'b0 || m1_tvalid !== 1'b0) begin errors++; $display("FAIL reset_pkt got dropped=%0b mvalid=%0b want 0 0", dr1, m1_tvalid); end
        areset = 1'b0;
    endtask

    task automatic fill16();
        m0_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s0_tvalid = 1'b1; s0_tdata = 8'(i); s0_tlast = (i == 15);
            tick();
            if (i == 0) begin
                checks++; if (m0_tvalid !== 1'b0) begin errors++; $display("FAIL stream_lat0 mvalid got %0b want 0", m0_tvalid); end
            end
            if (i == 1) begin
                checks++; if (m0_tvalid !== 1'b1 || m0_tdata !== 8'h00) begin errors++; $display("FAIL stream_lat1 got v=%0b d=%h want 1 00", m0_tvalid, m0_tdata); end
            end
        end
        s0_tvalid = 1'b0; s0_tlast = 1'b0;
        checks++; if (s0_tready !== 1'b0) begin errors++; $display("FAIL stream_full_sready got %0b want 0", s0_tready); end
        checks++; if (l0 !== 5'd16) begin errors++; $display("FAIL stream_full_level got %0d want 16", l0); end
    endtask

    task automatic test_stream();
        fill16();
        tick();
        checks++; if (m0_tvalid !== 1'b1 || m0_tdata !== 8'h00) begin errors++; $display("FAIL stream_hold got v=%0b d=%h want 1 00", m0_tvalid, m0_tdata); end
        m0_tready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            checks++; if (m0_tvalid !== 1'b1 || m0_tdata !== 8'(j)) begin errors++; $display("FAIL stream_drain got v=%0b d=%h want 1 %h", m0_tvalid, m0_tdata, 8'(j)); end
            tick();
        end
        checks++; if (m0_tvalid !== 1'b0 || l0 !== 5'd0) begin errors++; $display("FAIL stream_empty got v=%0b lvl=%0d want 0 0", m0_tvalid, l0); end
    endtask

    task automatic test_full_rw();
        fill16();
        for (int k = 0; k < 32; k++) begin
            s0_tvalid = 1'b1; s0_tdata = (k == 0) ? 8'hFF : 8'(15 + k); m0_tready = 1'b1;
            checks++; if (m0_tvalid !== 1'b1 || m0_tdata !== 8'(k)) begin errors++; $display("FAIL fullrw_data got v=%0b d=%h want 1 %h", m0_tvalid, m0_tdata, 8'(k)); end
            checks++; if (s0_tready !== (k != 0)) begin errors++; $display("FAIL fullrw_sready got %0b want %0b", s0_tready, (k != 0)); end
            tick();
            checks++; if (l0 !== 5'd15) begin errors++; $display("FAIL fullrw_level got %0d want 15", l0); end
        end
        s0_tvalid = 1'b0;
        for (int v = 32; v < 47; v++) begin
            checks++; if (m0_tvalid !== 1'b1 || m0_tdata !== 8'(v)) begin errors++; $display("FAIL fullrw_drain got v=%0b d=%h want 1 %h", m0_tvalid, m0_tdata, 8'(v)); end
            tick();
        end
        checks++; if (m0_tvalid !== 1'b0 || l0 !== 5'd0) begin errors++; $display("FAIL fullrw_empty got v=%0b lvl=%0d want 0 0", m0_tvalid, l0); end
    endtask

    task automatic test_packet_commit();
        logic [7:0] a [3];
        a[0] = 8'hA1; a[1] = 8'hA2; a[2] = 8'hA3;
        m1_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s1_tvalid = 1'b1; s1_tdata = a[i]; s1_tlast = (i == 2);
            tick();
            checks++; if (m1_tvalid !== 1'b0) begin errors++; $display("FAIL pkt_hidden beat%0d mvalid got %0b want 0", i, m1_tvalid); end
        end
        s1_tvalid = 1'b0; s1_tlast = 1'b0;
        checks++; if (l1 !== 5'd3) begin errors++; $display("FAIL pkt_level got %0d want 3", l1); end
        tick();
        m1_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (m1_tvalid !== 1'b1 || m1_tdata !== a[i] || m1_tlast !== (i == 2)) begin
                errors++; $display("FAIL pkt_out beat%0d got v=%0b d=%h l=%0b want 1 %h %0b", i, m1_tvalid, m1_tdata, m1_tlast, a[i], (i == 2)); end
            tick();
        end
        checks++; if (m1_tvalid !== 1'b0 || l1 !== 5'd0) begin errors++; $display("FAIL pkt_empty got v=%0b lvl=%0d want 0 0", m1_tvalid, l1); end
        m1_tready = 1'b0;
    endtask

    task automatic test_drop();
        m1_tready = 1'b0;
        s1_tvalid = 1'b1; s1_tdata = 8'hC1; s1_tlast = 1'b1; tick();
        s1_tdata = 8'hB1; s1_tlast = 1'b0; tick();
        s1_tdata = 8'hB2; tick();
        checks++; if (l1 !== 5'd3) begin errors++; $display("FAIL drop_prelevel got %0d want 3", l1); end
        s1_tdata = 8'hB3; s1_tlast = 1'b1; d1_drop = 1'b1; tick();
        s1_tvalid = 1'b0; s1_tlast = 1'b0; d1_drop = 1'b0;
        checks++; if (dr1 !== 1'b1) begin errors++; $display("FAIL drop_pulse got %0b want 1", dr1); end
        checks++; if (l1 !== 5'd1) begin errors++; $display("FAIL drop_level got %0d want 1", l1); end
        tick();
        checks++; if (dr1 !== 1'b0) begin errors++; $display("FAIL drop_pulse_end got %0b want 0", dr1); end
        m1_tready = 1'b1;
        checks++; if (m1_tvalid !== 1'b1 || m1_tdata !== 8'hC1 || m1_tlast !== 1'b1) begin
            errors++; $display("FAIL drop_keep got v=%0b d=%h l=%0b want 1 c1 1", m1_tvalid, m1_tdata, m1_tlast); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (m1_tvalid !== 1'b0 || l1 !== 5'd0) begin errors++; $display("FAIL drop_nothing got v=%0b lvl=%0d want 0 0", m1_tvalid, l1); end
        end
        m1_tready = 1'b0;
    endtask

    task automatic test_oversize();
        m2_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s2_tvalid = 1'b1; s2_tdata = 8'(8'hD1 + i); s2_tlast = 1'b0; tick();
        end
        s2_tdata = 8'hD5;
        checks++; if (s2_tready !== 1'b0 || l2 !== 3'd4) begin errors++; $display("FAIL ovf_full got rdy=%0b lvl=%0d want 0 4", s2_tready, l2); end
        tick();
        checks++; if (dr2 !== 1'b1 || l2 !== 3'd0 || s2_tready !== 1'b1) begin
            errors++; $display("FAIL ovf_drop got drp=%0b lvl=%0d rdy=%0b want 1 0 1", dr2, l2, s2_tready); end
        tick();
        checks++; if (dr2 !== 1'b0 || s2_tready !== 1'b1) begin errors++; $display("FAIL ovf_swallow got drp=%0b rdy=%0b want 0 1", dr2, s2_tready); end
        s2_tdata = 8'hD6; s2_tlast = 1'b1; tick();
        checks++; if (l2 !== 3'd0 || m2_tvalid !== 1'b0) begin errors++; $display("FAIL ovf_end got lvl=%0d v=%0b want 0 0", l2, m2_tvalid); end
        s2_tdata = 8'hE1; s2_tlast = 1'b0; tick();
        s2_tdata = 8'hE2; s2_tlast = 1'b1; tick();
        s2_tvalid = 1'b0; s2_tlast = 1'b0;
        checks++; if (l2 !== 3'd2) begin errors++; $display("FAIL ovf_next_level got %0d want 2", l2); end
        tick();
        m2_tready = 1'b1;
        checks++; if (m2_tvalid !== 1'b1 || m2_tdata !== 8'hE1 || m2_tlast !== 1'b0) begin
            errors++; $display("FAIL ovf_next0 got v=%0b d=%h l=%0b want 1 e1 0", m2_tvalid, m2_tdata, m2_tlast); end
        tick();
        checks++; if (m2_tvalid !== 1'b1 || m2_tdata !== 8'hE2 || m2_tlast !== 1'b1) begin
            errors++; $display("FAIL ovf_next1 got v=%0b d=%h l=%0b want 1 e2 1", m2_tvalid, m2_tdata, m2_tlast); end
        tick();
        checks++; if (m2_tvalid !== 1'b0 || l2 !== 3'd0) begin errors++; $display("FAIL ovf_empty got v=%0b lvl=%0d want 0 0", m2_tvalid, l2); end
    endtask

    task automatic test_reset_midframe();
        m1_tready = 1'b0;
        s1_tvalid = 1'b1; s1_tdata = 8'h61; s1_tlast = 1'b1; tick();
        s1_tdata = 8'h71; s1_tlast = 1'b0; tick();
        s1_tdata = 8'h72; tick();
        checks++; if (m1_tvalid !== 1'b1 || l1 !== 5'd3) begin errors++; $display("FAIL rstmid_pre got v=%0b lvl=%0d want 1 3", m1_tvalid, l1); end
        s1_tdata = 8'h73; areset = 1'b1; tick();
        checks++; if (m1_tvalid !== 1'b0 || l1 !== 5'd0 || s1_tready !== 1'b1) begin
            errors++; $display("FAIL rstmid_state got v=%0b lvl=%0d rdy=%0b want 0 0 1", m1_tvalid, l1, s1_tready); end
        checks++; if ({m1_tlast, m1_tdata} !== 9'h000) begin errors++; $display("FAIL rstmid_data got %h want 000", {m1_tlast, m1_tdata}); end
        areset = 1'b0; s1_tvalid = 1'b0; m1_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (m1_tvalid !== 1'b0 || l1 !== 5'd0) begin errors++; $display("FAIL rstmid_after got v=%0b lvl=%0d want 0 0", m1_tvalid, l1); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_full_rw();
        test_packet_commit();
        test_drop();
        test_oversize();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
